// File: rtl/regfile_reader_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_reader_pkg
//  Description : Shared sizing constants for the register-read stage and its
//                architectural register array.
//  Revision    : 1.0  initial release
// ============================================================================
package regfile_reader_pkg;

    localparam int XLEN      = 32;
    localparam int NREG      = 32;
    localparam int REG_IDX_W = 5;

endpackage : regfile_reader_pkg
`default_nettype wire

// File: rtl/regfile_reader_array.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_reader_array
//  Description : 2-read / 1-write architectural register array. Index 0 is
//                never written and always reads as zero; reset clears all.
//  Revision    : 1.0  initial release
// ============================================================================
module regfile_reader_array
    import regfile_reader_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 we,
    input  logic [REG_IDX_W-1:0] waddr,
    input  logic [XLEN-1:0]      wdata,
    input  logic [REG_IDX_W-1:0] raddr1,
    input  logic [REG_IDX_W-1:0] raddr2,
    output logic [XLEN-1:0]      rdata1,
    output logic [XLEN-1:0]      rdata2
);

    logic [XLEN-1:0] r_mem [NREG];

    // Storage update: reset clears every entry and drops a concurrent write
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                r_mem[i] <= '0;
            end
        end else if (we && (waddr != '0)) begin
            r_mem[waddr] <= wdata;
        end
    end

    // Asynchronous read ports with x0 forced to zero
    always_comb begin
        rdata1 = (raddr1 == '0) ? '0 : r_mem[raddr1];
        rdata2 = (raddr2 == '0) ? '0 : r_mem[raddr2];
    end

endmodule : regfile_reader_array
`default_nettype wire

// File: rtl/regfile_reader.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_reader
//  Description : Register-read stage. Reads two operands with same-cycle
//                writeback bypass, tracks in-flight producers in a one-bit
//                scoreboard to stall RAW/WAW hazards, and presents operands on
//                a registered valid/ready output.
//  Revision    : 1.0  initial release
// ============================================================================
module regfile_reader
    import regfile_reader_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [REG_IDX_W-1:0] in_rs1,
    input  logic [REG_IDX_W-1:0] in_rs2,
    input  logic [REG_IDX_W-1:0] in_rd,
    input  logic                 in_rd_wen,
    input  logic                 write_enable,
    input  logic [REG_IDX_W-1:0] write_rd,
    input  logic [XLEN-1:0]      write_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [XLEN-1:0]      out_rs1_data,
    output logic [XLEN-1:0]      out_rs2_data,
    output logic [REG_IDX_W-1:0] out_rd
);

    logic [NREG-1:0]  r_busy;
    logic [NREG-1:0]  w_clr;
    logic [NREG-1:0]  w_set;
    logic [XLEN-1:0]  w_arr_rs1;
    logic [XLEN-1:0]  w_arr_rs2;
    logic [XLEN-1:0]  w_op_rs1;
    logic [XLEN-1:0]  w_op_rs2;
    logic             w_hazard;
    logic             w_accept;

    regfile_reader_array u_array (
        .clk    (clk),
        .rst    (rst),
        .we     (write_enable),
        .waddr  (write_rd),
        .wdata  (write_data),
        .raddr1 (in_rs1),
        .raddr2 (in_rs2),
        .rdata1 (w_arr_rs1),
        .rdata2 (w_arr_rs2)
    );

    // Per-register scoreboard set/clear strobes; index 0 is never set
    for (genvar i = 0; i < NREG; i++) begin : g_sb
        assign w_clr[i] = write_enable && (write_rd == REG_IDX_W'(i));
        if (i == 0) begin : g_x0
            assign w_set[i] = 1'b0;
        end else begin : g_xn
            assign w_set[i] = w_accept && in_rd_wen && (in_rd == REG_IDX_W'(i));
        end
    end

    // Hazard check: a busy source/destination is released by a same-cycle writeback
    always_comb begin
        w_hazard = (r_busy[in_rs1] && !w_clr[in_rs1])
                || (r_busy[in_rs2] && !w_clr[in_rs2])
                || (in_rd_wen && r_busy[in_rd] && !w_clr[in_rd]);
        in_ready = !rst && (!out_valid || out_ready) && !w_hazard;
        w_accept = in_valid && in_ready;
    end

    // Operand selection with writeback bypass; x0 is always zero
    always_comb begin
        if (in_rs1 == '0) begin
            w_op_rs1 = '0;
        end else if (write_enable && (write_rd == in_rs1)) begin
            w_op_rs1 = write_data;
        end else begin
            w_op_rs1 = w_arr_rs1;
        end
        if (in_rs2 == '0) begin
            w_op_rs2 = '0;
        end else if (write_enable && (write_rd == in_rs2)) begin
            w_op_rs2 = write_data;
        end else begin
            w_op_rs2 = w_arr_rs2;
        end
    end

    // Scoreboard update: a set on the same index as a clear takes priority
    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy <= '0;
        end else begin
            for (int i = 0; i < NREG; i++) begin
                if (w_set[i]) begin
                    r_busy[i] <= 1'b1;
                end else if (w_clr[i]) begin
                    r_busy[i] <= 1'b0;
                end
            end
            r_busy[0] <= 1'b0;
        end
    end

    // Output register: load on accept, drop valid on drain, hold under backpressure
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid    <= 1'b0;
            out_rs1_data <= '0;
            out_rs2_data <= '0;
            out_rd       <= '0;
        end else if (w_accept) begin
            out_valid    <= 1'b1;
            out_rs1_data <= w_op_rs1;
            out_rs2_data <= w_op_rs2;
            out_rd       <= in_rd;
        end else if (out_valid && out_ready) begin
            out_valid    <= 1'b0;
        end
    end

endmodule : regfile_reader
`default_nettype wire

// File: doc/regfile_reader.md
# regfile_reader

Register-read stage and architectural register file sitting between decode and execute. Accepts one decoded instruction per cycle, reads two source operands from a 32-entry register file, and presents them on a registered valid/ready output. Absorbs the writeback stream produced by the writer stage, bypassing same-cycle writebacks into reads. A one-bit-per-register scoreboard stalls issue on RAW and WAW hazards against in-flight producers.

## Interface
- XLEN, 32, data width
- NREG, 32, architectural register count (index width log2(NREG) = 5)

- CLK  in  1  clock, all state updates on rising edge
- RST  in  1  synchronous, active-high reset
- IN_VALID  in  1  decode has an instruction
- IN_READY  out  1  stage accepts this cycle
- IN_RS1, IN_RS2  in  5  source register indices
- IN_RD  in  5  destination index
- IN_RD_WEN  in  1  instruction will write IN_RD
- WRITE_ENABLE  in  1  writeback strobe from writer (already 0 when rd = x0)
- WRITE_RD  in  5  writeback destination (writer's CTR_INFO.rd)
- WRITE_DATA  in  XLEN  writeback value
- OUT_VALID  out  1  operands valid
- OUT_READY  in  1  execute accepts
- OUT_RS1_DATA, OUT_RS2_DATA  out  XLEN  operand values
- OUT_RD  out  5  forwarded destination index

## Operation
- Register array: on edge, if WRITE_ENABLE && WRITE_RD != 0, reg[WRITE_RD] <= WRITE_DATA. x0 reads as 0 regardless of writes.
- Bypass: operand for rsN = 0 if rsN == 0; else WRITE_DATA if WRITE_ENABLE && WRITE_RD == rsN; else reg[rsN].
- Scoreboard busy[NREG-1:0], busy[0] hardwired 0.
  - clear_i = WRITE_ENABLE && WRITE_RD == i.
  - set_i = accept && IN_RD_WEN && IN_RD == i && i != 0.
  - set and clear same index same cycle: set wins.
- Hazard (combinational): (busy[IN_RS1] && !clear_RS1) || (busy[IN_RS2] && !clear_RS2) || (IN_RD_WEN && busy[IN_RD] && !clear_RD). Index 0 never hazards.
- IN_READY = !RST && (!OUT_VALID || OUT_READY) && !hazard. IN_READY depends combinationally on IN_RS1/IN_RS2/IN_RD/IN_RD_WEN and WRITE_*; not on IN_VALID.
- accept = IN_VALID && IN_READY: OUT_RS1_DATA/OUT_RS2_DATA <= bypassed operands, OUT_RD <= IN_RD, OUT_VALID <= 1.
- OUT_VALID && OUT_READY && !accept: OUT_VALID <= 0; data outputs hold last value.
- OUT_VALID && !OUT_READY: all OUT_* stable.
- Writebacks are never stalled; WRITE_* sampled every cycle.

## Timing
- Reset (RST high at edge): all registers 0, busy all 0, OUT_VALID 0, OUT_RS1_DATA/OUT_RS2_DATA 0, OUT_RD 0. IN_READY 0 while RST high.
- Reset mid-operation discards any held output and all scoreboard state; writebacks arriving while RST high are dropped.
- Latency: accept at edge N -> OUT_VALID high after edge N, data valid same cycle.
- Throughput: one instruction per cycle with OUT_READY held high and no hazards.
- Writeback at edge N visible through bypass during cycle before N, and through array after N.
- Stalled instruction waiting on rd: accepted in the same cycle the matching WRITE_ENABLE arrives, with the bypassed value.

## Structure
- Shared package def.sv: XLEN, NREG, REG_IDX_W = 5 constants; no new typedef needed beyond these.
- Sub-module regfile_array: 2-read/1-write array with x0 forcing and sync reset clear. Bypass, scoreboard, handshake and output register stay in regfile_reader.

## Test plan
- Reset, then IN_VALID with rs1=0, rs2=5 -> next cycle OUT_VALID=1, OUT_RS1_DATA=0, OUT_RS2_DATA=0.
- WRITE_ENABLE, WRITE_RD=5, WRITE_DATA=0xDEADBEEF same cycle as accept of rs1=5 -> OUT_RS1_DATA=0xDEADBEEF; later read of rs2=5 also 0xDEADBEEF.
- Accept rd=3 with IN_RD_WEN; next instruction rs2=3 -> IN_READY=0 until WRITE_ENABLE rd=3 data 0x00001234; accepted that cycle, OUT_RS2_DATA=0x00001234, busy[3] cleared.
- WAW: two instructions both rd=7 IN_RD_WEN -> second stalls until writeback to x7; simultaneous clear and set leaves busy[7]=1.
- Backpressure: OUT_READY=0 with OUT_VALID=1 -> IN_READY=0, OUT_* unchanged for 5 cycles; OUT_READY=1 -> pending input accepted same cycle, new data next cycle.
- WRITE_ENABLE with WRITE_RD=0, data 0xFFFFFFFF -> read x0 returns 0; accept rd=0 IN_RD_WEN -> no stall on following rs1=0; RST mid-stall -> OUT_VALID=0, busy cleared, register contents 0.
